dip_scan_controller: RTL and testbench
======================================

// Module: dip_scan_controller
// PURPOSE
//   Sequences periodic scans of the external 16-position DIP switch shift-register chain (74HC165-style).
//   Generates the chain serial clock and active-low parallel-load strobe, and shifts in WIDTH bits per scan.
//   Debounces successive scans and publishes a stable value to the CPU with a change-event valid/ack handshake.
//   Sits between the board DIP chain pins and the CPU I/O register file.
// PARAMETERS
//   WIDTH         16    bits per scan (chain length)
//   CLK_DIV       4     i_CLK cycles per half period of o_DIP_CLK (H); >=1
//   SCAN_GAP      1000  idle i_CLK cycles between end of one scan and next LOAD; >=1
//   STABLE_COUNT  3     consecutive identical scans required before publishing; >=1
// PORTS
//   i_CLK       in   1      system clock, all logic on posedge
//   i_RESET     in   1      synchronous, active-high reset
//   i_Enable    in   1      1 = run periodic scans
//   i_Data      in   1      serial data from chain output
//   i_Ack       in   1      CPU acknowledges o_Changed
//   o_DIP_CLK   out  1      chain serial clock (idle low)
//   o_DIPLatch  out  1      chain parallel load, active low
//   o_DIP16     out  WIDTH  debounced published switch value
//   o_Changed   out  1      new value published, held until acked
//   o_Busy      out  1      1 in LOAD/SHIFT/COMPARE
// BEHAVIOUR
//   Reset (any state, takes effect next cycle): state=IDLE, o_DIP_CLK=0, o_DIPLatch=1, o_DIP16=0,
//     o_Changed=0, o_Busy=0, shift reg=0, prev=0, stable_cnt=0, all counters=0. Partial scan discarded.
//   FSM: IDLE -> LOAD -> SHIFT_LO <-> SHIFT_HI -> COMPARE -> GAP -> LOAD | IDLE.
//   IDLE: outputs idle; i_Enable=1 -> LOAD next cycle.
//   LOAD: o_DIPLatch=0, o_DIP_CLK=0 for 2H cycles; then SHIFT_LO with bit index k=0.
//   SHIFT_LO: o_DIP_CLK=0 for H cycles; on last cycle sample i_Data into bit (WIDTH-1-k), MSB first.
//   SHIFT_HI: o_DIP_CLK=1 for H cycles (rising edge advances chain); k==WIDTH-1 -> COMPARE, else k++ -> SHIFT_LO.
//   COMPARE (1 cycle): if stable_cnt==0 or sample!=prev: prev=sample, stable_cnt=1;
//     else stable_cnt=min(stable_cnt+1, STABLE_COUNT).
//     Publish when updated stable_cnt==STABLE_COUNT and sample!=o_DIP16: o_DIP16=sample and o_Changed=1,
//     both visible the cycle after COMPARE.
//   GAP: SCAN_GAP cycles; then LOAD if i_Enable=1, else IDLE.
//   Scan length: 2H + WIDTH*2H + 1 cycles (137 at defaults).
//   i_Enable low mid-scan: current scan completes including COMPARE; GAP then IDLE. Enable is sampled only
//     in IDLE and at GAP end.
//   Handshake: o_Changed clears the cycle after i_Ack=1. If a publish and i_Ack coincide, o_Changed stays 1.
//     o_DIP16 always shows the latest published value, even while o_Changed is pending. i_Ack with
//     o_Changed=0 is ignored.
//   Sample equal to o_DIP16 at full stability: no publish, no o_Changed. So all-zero switches after reset
//     never raise o_Changed.
//   stable_cnt saturates; a long-stable value never republishes.
//   Counter widths sized by $clog2 of parameters; no wrap inside a scan.
// TESTING (WIDTH=16, CLK_DIV=2, SCAN_GAP=10, STABLE_COUNT=3)
//   1 Reset, i_Enable=1, chain=16'hA5C3 -> each scan has o_DIPLatch low 4 cycles and 16 o_DIP_CLK rises.
//     o_DIP16=16'hA5C3 and o_Changed=1 the cycle after the 3rd COMPARE; none earlier.
//   2 Bit order: chain=16'h8001 -> published value 16'h8001 (first sampled bit lands in bit 15).
//   3 Bounce: chain alternates A5C3/A5C2 per scan for 6 scans -> no publish. Then A5C2 held 3 scans ->
//     o_DIP16=16'hA5C2.
//   4 Ack: i_Ack held low -> o_Changed stays 1 across scans. 1-cycle ack -> 0 next cycle. Ack in the
//     publish cycle -> o_Changed stays 1 and o_DIP16 shows the new value.
//   5 i_RESET=1 during SHIFT at k=7 -> next cycle o_DIP_CLK=0, o_DIPLatch=1, o_Busy=0, o_DIP16=0,
//     o_Changed=0. After release with i_Enable=1, scanning restarts from LOAD.
//   6 i_Enable dropped mid-SHIFT -> scan and COMPARE complete, then GAP, then IDLE. No further
//     o_DIPLatch pulses; o_Busy=0.

Source files
------------

// File: rtl/dip_scan_controller.sv
// Periodic scanner for a 74HC165-style DIP switch chain.
// Debounces successive scans and publishes changes with a valid/ack handshake.
module dip_scan_controller #(
    parameter int WIDTH        = 16,
    parameter int CLK_DIV      = 4,
    parameter int SCAN_GAP     = 1000,
    parameter int STABLE_COUNT = 3
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_Enable,
    input  logic             i_Data,
    input  logic             i_Ack,
    output logic             o_DIP_CLK,
    output logic             o_DIPLatch,
    output logic [WIDTH-1:0] o_DIP16,
    output logic             o_Changed,
    output logic             o_Busy
);

    localparam int CMAX = (2 * CLK_DIV > SCAN_GAP) ? 2 * CLK_DIV : SCAN_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int KW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW   = $clog2(STABLE_COUNT + 1);

    localparam logic [CW-1:0] H_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] L_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] G_LAST = CW'(SCAN_GAP - 1);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
    localparam logic [SW-1:0] S_MAX  = SW'(STABLE_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_COMPARE,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [WIDTH-1:0] dip16_q, dip16_d;
    logic             changed_q, changed_d;
    logic             dip_clk_q, dip_clk_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;

    logic [KW-1:0]    idx;
    logic [SW-1:0]    stab_new;
    logic             publish;

    assign idx = K_LAST - k_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        shift_d  = shift_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        stab_new = '0;
        publish  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_Enable) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == L_LAST) begin
                    state_d = S_SHIFT_LO;
                    cnt_d   = '0;
                    k_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT_LO: begin
                if (cnt_q == H_LAST) begin
                    shift_d[idx] = i_Data;
                    state_d      = S_SHIFT_HI;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q == H_LAST) begin
                    cnt_d = '0;
                    if (k_q == K_LAST) begin
                        state_d = S_COMPARE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMPARE: begin
                if (stable_q == '0 || shift_q != prev_q) begin
                    prev_d   = shift_q;
                    stab_new = SW'(1);
                end else if (stable_q == S_MAX) begin
                    stab_new = stable_q;
                end else begin
                    stab_new = stable_q + 1'b1;
                end
                stable_d = stab_new;
                publish  = (stab_new == S_MAX) && (shift_q != dip16_q);
                state_d  = S_GAP;
                cnt_d    = '0;
            end
            S_GAP: begin
                if (cnt_q == G_LAST) begin
                    cnt_d   = '0;
                    state_d = i_Enable ? S_LOAD : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A publish in the same cycle as an ack wins, so the new value is never lost
        changed_d = publish | (changed_q & ~i_Ack);
        dip16_d   = publish ? shift_q : dip16_q;
        dip_clk_d = (state_d == S_SHIFT_HI);
        latch_d   = (state_d != S_LOAD);
        busy_d    = (state_d == S_LOAD) || (state_d == S_SHIFT_LO) ||
                    (state_d == S_SHIFT_HI) || (state_d == S_COMPARE);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            shift_q   <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            dip16_q   <= '0;
            changed_q <= 1'b0;
            dip_clk_q <= 1'b0;
            latch_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            shift_q   <= shift_d;
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            dip16_q   <= dip16_d;
            changed_q <= changed_d;
            dip_clk_q <= dip_clk_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
        end
    end

    assign o_DIP_CLK  = dip_clk_q;
    assign o_DIPLatch = latch_q;
    assign o_DIP16    = dip16_q;
    assign o_Changed  = changed_q;
    assign o_Busy     = busy_q;

endmodule

// File: tb/tb_dip_scan_controller.sv
// Bench for dip_scan_controller: a behavioural 74HC165 chain, a scan-history
// debounce model feeding a publish queue, and a monitor that drains it.
module tb_dip_scan_controller;

    localparam int W  = 16;
    localparam int H  = 2;
    localparam int G  = 10;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          i_RESET = 1'b1;
    logic          i_Enable = 1'b0;
    logic          i_Data;
    logic          i_Ack = 1'b0;
    logic          o_DIP_CLK;
    logic          o_DIPLatch;
    logic [W-1:0]  o_DIP16;
    logic          o_Changed;
    logic          o_Busy;

    dip_scan_controller #(
        .WIDTH(W), .CLK_DIV(H), .SCAN_GAP(G), .STABLE_COUNT(SC)
    ) dut (
        .i_CLK(clk), .i_RESET(i_RESET), .i_Enable(i_Enable),
        .i_Data(i_Data), .i_Ack(i_Ack), .o_DIP_CLK(o_DIP_CLK),
        .o_DIPLatch(o_DIPLatch), .o_DIP16(o_DIP16),
        .o_Changed(o_Changed), .o_Busy(o_Busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Switch bank and shift-register chain
    logic [W-1:0] sw = '0;
    logic [W-1:0] chain = '0;
    assign i_Data = chain[W-1];

    // Reference model: a scan publishes once the last SC scans agree and differ from the published value
    logic [W-1:0] hist[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pub = '0;

    always @(negedge o_DIPLatch) begin
        bit same;
        chain = sw;
        hist.push_back(sw);
        if (hist.size() > SC) void'(hist.pop_front());
        same = (hist.size() == SC);
        foreach (hist[i]) if (hist[i] != sw) same = 0;
        if (same && sw != pub) begin
            pub = sw;
            exp_q.push_back(sw);
        end
    end

    always @(posedge o_DIP_CLK) chain = chain << 1;

    // Monitor
    bit           mon_en = 0;
    logic         rst_s = 1'b1;
    logic [W-1:0] last = '0;
    logic         busy_prev = 1'b0, clk_prev = 1'b0, latch_prev = 1'b1;
    int           latch_low_cnt = 0;
    int           rises = 0;
    int           latch_falls = 0;

    always @(posedge clk) rst_s <= i_RESET;

    always @(negedge clk) begin
        if (mon_en && !rst_s) begin
            if (!o_DIPLatch) latch_low_cnt++;
            else if (latch_low_cnt != 0) begin
                chk("latch_low_len", latch_low_cnt, 2 * H);
                latch_low_cnt = 0;
            end
            if (!o_DIPLatch && latch_prev) begin
                rises = 0;
                latch_falls++;
            end
            if (o_DIP_CLK && !clk_prev) rises++;
            if (busy_prev && !o_Busy) chk("clk_rises", rises, W);
            if (o_DIP16 !== last) begin
                if (exp_q.size() == 0) chk("unexpected_publish", int'(o_DIP16), int'(last));
                else chk("publish_val", int'(o_DIP16), int'(exp_q.pop_front()));
                chk("publish_changed", int'(o_Changed), 1);
                chk("publish_timing", int'({busy_prev, o_Busy}), 2);
                last = o_DIP16;
            end
        end else begin
            latch_low_cnt = 0;
            last = o_DIP16;
        end
        busy_prev  = o_Busy;
        clk_prev   = o_DIP_CLK;
        latch_prev = o_DIPLatch;
    end

    task automatic wait_scans(input int n, input bit rnd_ack);
        int seen = 0;
        int t = 0;
        bit pb = o_Busy;
        while (seen < n && t < n * 200) begin
            @(negedge clk);
            t++;
            if (rnd_ack) i_Ack = ($urandom_range(0, 15) == 0);
            if (pb && !o_Busy) seen++;
            pb = o_Busy;
        end
        i_Ack = 1'b0;
        if (seen < n) chk("scan_timeout", seen, n);
    endtask

    task automatic wait_latch_fall();
        int t = 0;
        bit lp = o_DIPLatch;
        bit hit = 0;
        while (!hit && t < 300) begin
            @(negedge clk);
            t++;
            hit = lp && !o_DIPLatch;
            lp = o_DIPLatch;
        end
        if (!hit) chk("latch_timeout", 0, 1);
    endtask

    task automatic wait_rises(input int n);
        int t = 0;
        while (rises < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (rises < n) chk("rise_timeout", rises, n);
    endtask

    task automatic ack_pulse();
        i_Ack = 1'b1;
        @(negedge clk);
        i_Ack = 1'b0;
    endtask

    task automatic flush_model();
        hist.delete();
        exp_q.delete();
        pub = '0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_clk"}, int'(o_DIP_CLK), 0);
        chk({tag, "_latch"}, int'(o_DIPLatch), 1);
        chk({tag, "_dip16"}, int'(o_DIP16), 0);
        chk({tag, "_changed"}, int'(o_Changed), 0);
        chk({tag, "_busy"}, int'(o_Busy), 0);
    endtask

    logic [W-1:0] pool [3] = '{16'h1357, 16'hFFFF, 16'h0F0F};

    initial begin
        int snap;
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_RESET = 1'b0;
        flush_model();
        chk_idle("reset");
        mon_en = 1;

        // 1: first publish only after the third agreeing scan
        sw = 16'hA5C3;
        i_Enable = 1'b1;
        wait_scans(2, 0);
        chk("early_dip16", int'(o_DIP16), 0);
        chk("early_changed", int'(o_Changed), 0);
        wait_scans(1, 0);
        chk("t1_dip16", int'(o_DIP16), 16'hA5C3);
        chk("t1_changed", int'(o_Changed), 1);

        // 2: bit order
        ack_pulse();
        sw = 16'h8001;
        wait_scans(3, 0);
        chk("t2_dip16", int'(o_DIP16), 16'h8001);
        ack_pulse();

        // 3: bouncing chain never publishes
        for (int s = 0; s < 6; s++) begin
            sw = s[0] ? 16'hA5C3 : 16'hA5C2;
            wait_scans(1, 0);
        end
        chk("t3_bounce", int'(o_DIP16), 16'h8001);
        sw = 16'hA5C2;
        wait_scans(3, 0);
        chk("t3_dip16", int'(o_DIP16), 16'hA5C2);

        // 4: handshake
        wait_scans(1, 0);
        chk("t4_hold", int'(o_Changed), 1);
        ack_pulse();
        chk("t4_acked", int'(o_Changed), 0);
        sw = 16'h1234;
        wait_scans(3, 0);
        chk("t4_pend", int'(o_Changed), 1);
        sw = 16'h4321;
        wait_scans(2, 0);
        wait_latch_fall();
        repeat (2 * H + 2 * H * W) @(negedge clk);
        chk("t4_cmp_busy", int'(o_Busy), 1);
        i_Ack = 1'b1;
        @(negedge clk);
        i_Ack = 1'b0;
        chk("t4_coinc_changed", int'(o_Changed), 1);
        chk("t4_coinc_dip16", int'(o_DIP16), 16'h4321);
        ack_pulse();
        chk("t4_final", int'(o_Changed), 0);

        // 5: reset mid-shift, then restart from LOAD
        sw = 16'hBEEF;
        wait_latch_fall();
        wait_rises(7);
        repeat (H) @(negedge clk);
        i_RESET = 1'b1;
        @(negedge clk);
        chk_idle("t5");
        i_RESET = 1'b0;
        flush_model();
        t = 0;
        while (o_DIPLatch && t < 5) begin
            @(negedge clk);
            t++;
        end
        chk("t5_restart_latch", int'(o_DIPLatch), 0);
        chk("t5_restart_busy", int'(o_Busy), 1);
        wait_scans(3, 0);
        chk("t5_dip16", int'(o_DIP16), 16'hBEEF);

        // randomized phase
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 9) < 4) sw = pool[$urandom_range(0, 2)];
            wait_scans(1, 1);
        end

        // 6: enable dropped mid-shift
        wait_latch_fall();
        wait_rises(5);
        i_Enable = 1'b0;
        wait_scans(1, 0);
        snap = latch_falls;
        repeat (G + 80) @(negedge clk);
        chk("t6_no_latch", latch_falls, snap);
        chk("t6_busy", int'(o_Busy), 0);
        chk("t6_latch_hi", int'(o_DIPLatch), 1);
        chk("t6_clk_lo", int'(o_DIP_CLK), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
